ibex_rvfi_trace_fifo: RTL and testbench

Consumer end of the Ibex RVFI retirement port. Captures each retired instruction into a compact trace record and buffers the records in a small FIFO. Records drain to a trace sink over a valid/ready handshake. Also checks that rvfi order increments by exactly one, and counts records dropped on overflow. Sits in the DV/trace path between the core's RVFI outputs and a trace writer or scoreboard.

---
 rtl/ibex_rvfi_trace_pkg.sv | 22 ++
 rtl/ibex_rvfi_trace_fifo_mem.sv | 50 +++++
 rtl/ibex_rvfi_trace_fifo.sv | 102 ++++++++++
 tb/tb_ibex_rvfi_trace_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ibex_rvfi_trace_pkg.sv
// ibex_rvfi_trace_pkg: trace record layout and order-checker state encoding
package ibex_rvfi_trace_pkg;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [1:0]  mode;
        logic        trap;
        logic        gap;
    } rvfi_trace_rec_t;

    localparam int RecW = $bits(rvfi_trace_rec_t);

    typedef enum logic {ORD_IDLE, ORD_TRACK} ord_state_e;

endpackage

// File: rtl/ibex_rvfi_trace_fifo_mem.sv
// ibex_rvfi_trace_fifo_mem: generic first-word-fall-through FIFO with registered storage
module ibex_rvfi_trace_fifo_mem #(
    parameter int Width = 8,
    parameter int Depth = 8,
    localparam int AW = $clog2(Depth)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [Width-1:0] o_rdata,
    output logic [AW:0]      o_level
);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_level;
    logic             w_pop, w_push;

    assign w_pop   = i_pop && r_level != '0;
    assign w_push  = i_push && (r_level != (AW+1)'(Depth) || w_pop);
    assign o_valid = r_level != '0;
    // Head is forced to zero when empty so the output is defined out of reset
    assign o_rdata = o_valid ? r_mem[r_rd] : '0;
    assign o_level = r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_clear) r_mem[r_wr] <= i_wdata;
    end

endmodule

// File: rtl/ibex_rvfi_trace_fifo.sv
// ibex_rvfi_trace_fifo: captures RVFI retirements into buffered trace records, checks order, counts drops
module ibex_rvfi_trace_fifo
    import ibex_rvfi_trace_pkg::*;
#(
    parameter int Depth = 8,
    parameter int CntW  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     rvfi_valid_i,
    input  logic [63:0]              rvfi_order_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic                     rvfi_trap_i,
    input  logic [1:0]               rvfi_mode_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [4:0]               rvfi_rd_addr_i,
    input  logic [31:0]              rvfi_rd_wdata_i,
    input  logic [31:0]              rvfi_mem_addr_i,
    input  logic [3:0]               rvfi_mem_rmask_i,
    input  logic [3:0]               rvfi_mem_wmask_i,
    output logic                     trace_valid_o,
    input  logic                     trace_ready_i,
    output rvfi_trace_rec_t          trace_rec_o,
    output logic [$clog2(Depth):0]   level_o,
    output logic [CntW-1:0]          drop_cnt_o,
    output logic                     order_err_o
);

    rvfi_trace_rec_t  w_rec;
    logic [RecW-1:0]  w_rdata;
    logic             w_full, w_pop, w_push, w_drop, w_err_set;
    logic             r_gap_pending, r_order_err;
    logic [CntW-1:0]  r_drop_cnt;
    logic [63:0]      r_last_order;
    ord_state_e       r_ord_state, w_ord_next;

    assign w_full = level_o == ($clog2(Depth)+1)'(Depth);
    assign w_pop  = trace_valid_o && trace_ready_i;
    assign w_push = rvfi_valid_i && (!w_full || w_pop) && !clear_i;
    assign w_drop = rvfi_valid_i && w_full && !w_pop && !clear_i;

    assign w_rec = '{
        order:     rvfi_order_i,
        pc:        rvfi_pc_rdata_i,
        insn:      rvfi_insn_i,
        rd_addr:   rvfi_rd_addr_i,
        rd_wdata:  rvfi_rd_wdata_i,
        mem_addr:  rvfi_mem_addr_i,
        mem_rmask: rvfi_mem_rmask_i,
        mem_wmask: rvfi_mem_wmask_i,
        mode:      rvfi_mode_i,
        trap:      rvfi_trap_i,
        gap:       r_gap_pending
    };

    ibex_rvfi_trace_fifo_mem #(.Width(RecW), .Depth(Depth)) u_mem (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_clear (clear_i),
        .i_push  (w_push),
        .i_wdata (w_rec),
        .i_pop   (w_pop),
        .o_valid (trace_valid_o),
        .o_rdata (w_rdata),
        .o_level (level_o)
    );

    assign trace_rec_o = rvfi_trace_rec_t'(w_rdata);
    assign drop_cnt_o  = r_drop_cnt;
    assign order_err_o = r_order_err;

    // Dropped retirements still advance the order check
    always_comb begin
        w_ord_next = rvfi_valid_i ? ORD_TRACK : r_ord_state;
        w_err_set  = r_ord_state == ORD_TRACK && rvfi_valid_i && rvfi_order_i != r_last_order + 64'd1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ord_state   <= ORD_IDLE;
            r_last_order  <= '0;
            r_order_err   <= 1'b0;
            r_drop_cnt    <= '0;
            r_gap_pending <= 1'b0;
        end else if (clear_i) begin
            r_ord_state   <= ORD_IDLE;
            r_last_order  <= '0;
            r_order_err   <= 1'b0;
            r_drop_cnt    <= '0;
            r_gap_pending <= 1'b0;
        end else begin
            r_ord_state <= w_ord_next;
            if (rvfi_valid_i) r_last_order <= rvfi_order_i;
            if (w_err_set) r_order_err <= 1'b1;
            if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_drop) r_gap_pending <= 1'b1;
            else if (w_push) r_gap_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_fifo.sv
// tb_ibex_rvfi_trace_fifo: directed scoreboard bench for the RVFI trace FIFO
module tb_ibex_rvfi_trace_fifo;
    import ibex_rvfi_trace_pkg::*;

    localparam int Depth = 8;
    localparam int CntW  = 16;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clear_i = 1'b0;
    logic            rvfi_valid_i = 1'b0;
    logic [63:0]     rvfi_order_i = '0;
    logic [31:0]     rvfi_insn_i = '0;
    logic            rvfi_trap_i = 1'b0;
    logic [1:0]      rvfi_mode_i = '0;
    logic [31:0]     rvfi_pc_rdata_i = '0;
    logic [4:0]      rvfi_rd_addr_i = '0;
    logic [31:0]     rvfi_rd_wdata_i = '0;
    logic [31:0]     rvfi_mem_addr_i = '0;
    logic [3:0]      rvfi_mem_rmask_i = '0;
    logic [3:0]      rvfi_mem_wmask_i = '0;
    logic            trace_valid_o;
    logic            trace_ready_i = 1'b0;
    rvfi_trace_rec_t trace_rec_o;
    logic [3:0]      level_o;
    logic [CntW-1:0] drop_cnt_o;
    logic            order_err_o;

    int tests = 0;
    int fails = 0;

    rvfi_trace_rec_t q[$];
    logic [CntW-1:0] m_drop = '0;
    bit              m_err = 0, m_gap = 0, m_track = 0;
    logic [63:0]     m_last = '0;

    always #5 clk_i = ~clk_i;

    ibex_rvfi_trace_fifo #(.Depth(Depth), .CntW(CntW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i),
        .rvfi_trap_i(rvfi_trap_i), .rvfi_mode_i(rvfi_mode_i), .rvfi_pc_rdata_i(rvfi_pc_rdata_i),
        .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
        .rvfi_mem_addr_i(rvfi_mem_addr_i), .rvfi_mem_rmask_i(rvfi_mem_rmask_i),
        .rvfi_mem_wmask_i(rvfi_mem_wmask_i), .trace_valid_o(trace_valid_o),
        .trace_ready_i(trace_ready_i), .trace_rec_o(trace_rec_o), .level_o(level_o),
        .drop_cnt_o(drop_cnt_o), .order_err_o(order_err_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rvfi_trace_rec_t mk(input logic [63:0] o, input bit g);
        rvfi_trace_rec_t r;
        r.order     = o;
        r.pc        = 32'h0000_1000 + o[31:0] * 4;
        r.insn      = 32'h0013_0000 ^ (o[31:0] * 32'h9E37);
        r.rd_addr   = o[4:0] ^ 5'h15;
        r.rd_wdata  = 32'hA5A5_0000 + o[31:0];
        r.mem_addr  = 32'h8000_0000 | (o[31:0] << 2);
        r.mem_rmask = o[3:0];
        r.mem_wmask = ~o[3:0];
        r.mode      = o[2:1];
        r.trap      = o[0];
        r.gap       = g;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_drop = '0; m_err = 0; m_gap = 0; m_track = 0; m_last = '0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_level"}, level_o, q.size());
        chk({tag, "_valid"}, trace_valid_o, q.size() != 0);
        chk({tag, "_drop"}, drop_cnt_o, m_drop);
        chk({tag, "_oerr"}, order_err_o, m_err);
    endtask

    // Called at posedge+1; checks current outputs, drives one cycle of stimulus, advances the model
    task automatic cyc(input bit v, input logic [63:0] ord, input bit rdy, input bit clr = 0);
        rvfi_trace_rec_t r, e;
        int  sz;
        bit  pop;
        check_state("cyc");
        sz  = q.size();
        pop = sz != 0 && rdy;
        if (pop && !clr) begin
            e = q.pop_front();
            chk("rec", trace_rec_o, e);
        end
        r = mk(ord, m_gap);
        rvfi_valid_i     = v;
        rvfi_order_i     = r.order;
        rvfi_insn_i      = r.insn;
        rvfi_trap_i      = r.trap;
        rvfi_mode_i      = r.mode;
        rvfi_pc_rdata_i  = r.pc;
        rvfi_rd_addr_i   = r.rd_addr;
        rvfi_rd_wdata_i  = r.rd_wdata;
        rvfi_mem_addr_i  = r.mem_addr;
        rvfi_mem_rmask_i = r.mem_rmask;
        rvfi_mem_wmask_i = r.mem_wmask;
        trace_ready_i    = rdy;
        clear_i          = clr;
        @(posedge clk_i); #1;
        rvfi_valid_i = 1'b0;
        clear_i      = 1'b0;
        if (clr) model_reset();
        else if (v) begin
            if (sz < Depth || pop) begin
                q.push_back(r);
                m_gap = 0;
            end else begin
                if (m_drop != '1) m_drop = m_drop + 1'b1;
                m_gap = 1;
            end
            if (m_track && ord != m_last + 64'd1) m_err = 1;
            m_last  = ord;
            m_track = 1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, trace_valid_o, 1'b0);
        chk({tag, "_level"}, level_o, 4'd0);
        chk({tag, "_drop"}, drop_cnt_o, '0);
        chk({tag, "_oerr"}, order_err_o, 1'b0);
        chk({tag, "_rec"}, trace_rec_o, '0);
    endtask

    initial begin
        #12;
        chk_reset("por");
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Basic pass-through
        cyc(1, 0, 1); cyc(1, 1, 1); cyc(1, 2, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);

        // Overflow, drain, gap marking
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, i, 0);
        chk("ovf_level", level_o, 4'd8);
        chk("ovf_drop", drop_cnt_o, 16'd2);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1);
        cyc(1, 10, 1);
        cyc(1, 11, 1);
        cyc(0, 0, 1); cyc(0, 0, 1);

        // Full with simultaneous pop and push
        for (int i = 12; i < 20; i++) cyc(1, i, 0);
        chk("full_level", level_o, 4'd8);
        cyc(1, 20, 1);
        chk("fullpop_level", level_o, 4'd8);
        chk("fullpop_drop", drop_cnt_o, 16'd2);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1);

        // Order discontinuity, first valid after clear unchecked
        cyc(0, 0, 1, 1);
        cyc(1, 5, 1); cyc(1, 6, 1);
        chk("ord_pre", order_err_o, 1'b0);
        cyc(1, 8, 1);
        chk("ord_set", order_err_o, 1'b1);
        cyc(1, 9, 1); cyc(1, 10, 1);
        chk("ord_sticky", order_err_o, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);

        // Clear with queued entries and coincident valid
        for (int i = 30; i < 34; i++) cyc(1, i, 0);
        chk("preclr_level", level_o, 4'd4);
        cyc(1, 50, 0, 1);
        chk("clr_level", level_o, 4'd0);
        chk("clr_valid", trace_valid_o, 1'b0);
        chk("clr_drop", drop_cnt_o, 16'd0);
        chk("clr_oerr", order_err_o, 1'b0);
        cyc(1, 100, 1);
        cyc(0, 0, 1);
        chk("clr_noerr", order_err_o, 1'b0);
        cyc(0, 0, 1);

        // Drop counter saturation
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 65548; i++) cyc(1, i, 0);
        chk("sat_drop", drop_cnt_o, 16'hFFFF);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1);

        // Asynchronous reset mid-burst
        cyc(0, 0, 0, 1);
        cyc(1, 200, 0); cyc(1, 201, 0); cyc(1, 203, 0);
        chk("prerst_level", level_o, 4'd3);
        chk("prerst_oerr", order_err_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1 chk_reset("arst");
        model_reset();
        @(negedge clk_i); rst_ni = 1'b1;
        @(posedge clk_i); #1;
        cyc(1, 7, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
